// File: rtl/mips_dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: MMIO offsets, STATUS/CTRL bit positions,
// decode target type and the STATUS word packer.
package mips_dmem_responder_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [15:0] OFS_CYCLE  = 16'h0000;
  localparam logic [15:0] OFS_OUT    = 16'h0004;
  localparam logic [15:0] OFS_STATUS = 16'h0008;
  localparam logic [15:0] OFS_CTRL   = 16'h000C;

  localparam int unsigned ST_FULL    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_CNT_LSB = 4;
  localparam int unsigned ST_CNT_W   = 4;
  localparam int unsigned ST_OVF     = 8;

  localparam int unsigned CTRL_CLR_CYCLE = 0;
  localparam int unsigned CTRL_CLR_OVF   = 1;

  typedef enum logic {
    TGT_RAM  = 1'b0,
    TGT_MMIO = 1'b1
  } target_e;

  // Assembles the STATUS read value; unlisted bits stay zero.
  function automatic logic [DATA_W-1:0] pack_status(input logic full, input logic empty,
                                                    input logic [ST_CNT_W-1:0] cnt,
                                                    input logic ovf);
    logic [DATA_W-1:0] s;
    s = '0;
    s[ST_FULL]                     = full;
    s[ST_EMPTY]                    = empty;
    s[ST_CNT_LSB +: ST_CNT_W]      = cnt;
    s[ST_OVF]                      = ovf;
    return s;
  endfunction

endpackage

// File: rtl/mips_dmem_responder_if.sv
// Core data-memory bus plus the output-FIFO valid/ready stream, bundled for the responder.
interface mips_dmem_responder_if;
  import mips_dmem_responder_pkg::*;

  logic              mem_ren;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;
  logic [DATA_W-1:0] mem_din;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output mem_ren, mem_wen, mem_addr, mem_dout, out_ready,
    input  mem_din, out_valid, out_data
  );

  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_dout, out_ready,
    output mem_din, out_valid, out_data
  );
endinterface

// File: rtl/mips_dmem_responder_out_fifo.sv
// First-word-fall-through output FIFO; a push while full without a pop is dropped and
// reported on overflow for one cycle.
module mips_dmem_responder_out_fifo
  import mips_dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_W-1:0]             din,
  output logic [DATA_W-1:0]             dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          overflow
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;
  assign dout     = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; empty masks stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder: word RAM plus MMIO (CYCLE, OUT FIFO, STATUS, CTRL).
// Optional second RAM read port under DMEM_DEBUG_PORT_EN.
module mips_dmem_responder
  import mips_dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] MMIO_TAG   = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  mips_dmem_responder_if.slave  bus
`ifdef DMEM_DEBUG_PORT_EN
  ,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
`endif
);
  localparam int unsigned RAM_WORDS = 1 << ADDR_WIDTH;
  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0]     ram [RAM_WORDS];
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic [15:0]           ofs;
  target_e               tgt;
  logic [DATA_W-1:0]     cycle_q;
  logic                  ovf_q;
  logic                  ram_we;
  logic                  out_push;
  logic                  ctrl_we;
  logic                  cyc_clr;
  logic                  ovf_clr;
  logic                  ovf_evt;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [DATA_W-1:0]     cnt_ext;
  logic [ST_CNT_W-1:0]   stat_cnt;
  logic [DATA_W-1:0]     status;

  assign tgt      = (bus.mem_addr[31:16] == MMIO_TAG) ? TGT_MMIO : TGT_RAM;
  assign ofs      = bus.mem_addr[15:0];
  assign ram_idx  = bus.mem_addr[ADDR_WIDTH+1:2];
  assign ram_we   = bus.mem_wen && (tgt == TGT_RAM);
  assign out_push = bus.mem_wen && (tgt == TGT_MMIO) && (ofs == OFS_OUT);
  assign ctrl_we  = bus.mem_wen && (tgt == TGT_MMIO) && (ofs == OFS_CTRL);
  assign cyc_clr  = ctrl_we && bus.mem_dout[CTRL_CLR_CYCLE];
  assign ovf_clr  = ctrl_we && bus.mem_dout[CTRL_CLR_OVF];

  assign cnt_ext  = DATA_W'(fifo_count);
  assign stat_cnt = (cnt_ext > 32'd15) ? 4'hF : cnt_ext[ST_CNT_W-1:0];
  assign status   = pack_status(fifo_full, fifo_empty, stat_cnt, ovf_q);

  assign bus.out_valid = !fifo_empty;

  mips_dmem_responder_out_fifo #(
    .DEPTH    (FIFO_DEPTH)
  ) u_out_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (out_push),
    .pop      (bus.out_ready),
    .din      (bus.mem_dout),
    .dout     (bus.out_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .overflow (ovf_evt)
  );

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= bus.mem_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cycle_q <= '0;
    else if (cyc_clr) cycle_q <= '0;
    else              cycle_q <= cycle_q + 32'd1;
  end

  // A new overflow event beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ovf_q <= 1'b0;
    else if (ovf_evt) ovf_q <= 1'b1;
    else if (ovf_clr) ovf_q <= 1'b0;
  end

  always_comb begin
    bus.mem_din = '0;
    if (bus.mem_ren) begin
      if (tgt == TGT_MMIO) begin
        case (ofs)
          OFS_CYCLE:  bus.mem_din = cycle_q;
          OFS_STATUS: bus.mem_din = status;
          default:    bus.mem_din = '0;
        endcase
      end else begin
        bus.mem_din = ram[ram_idx];
      end
    end
  end

`ifdef DMEM_DEBUG_PORT_EN
  assign dbg_data = ram[dbg_addr];
`endif

endmodule
